// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and constants for the data-memory controller.
//   state_t        controller states (DRAIN is reachable only when the write
//                  buffer is compiled in with DMEM_CTRL_WBUF_EN)
//   DEF_*          default parameter values for address/data width and timeout
//   STALL_CNT_MAX  saturation value of the stall-cycle counter
//   sat_inc()      saturating increment used by the stall counter
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 64;

   localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == STALL_CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry write buffer for dmem_ctrl (used only when the
// controller is built with DMEM_CTRL_WBUF_EN).
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_addr/data  capture a store into the entry
//   pop                   release the entry once memory has taken it
//   full                  entry holds a store not yet written
//   addr, data            contents of the entry
module dmem_wbuf
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (push) begin
         valid_q <= 1'b1;
         addr_q  <= push_addr;
         data_q  <= push_data;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end

   assign full = valid_q;
   assign addr = addr_q;
   assign data = data_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller between the MEM stage and a
// variable-latency data memory.
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   cpu_req_i/we/addr/wdata   MEM-stage load/store request
//   cpu_rdata_o         registered load data, held until the next load
//   cpu_stall_o         freezes the pipeline while an access is outstanding
//   mem_enable_o/write/addr/wdata   request to memory
//   mem_ack_i, mem_rdata_i          one-cycle completion from memory
//   timeout_o           sticky: an access was aborted after TIMEOUT cycles
//   stall_cnt_o         saturating count of stalled cycles
// Build option: DMEM_CTRL_WBUF_EN compiles in a one-entry write buffer so a
// store in IDLE retires without stalling and drains in the DRAIN state.
//
// Handshakes: the CPU side holds cpu_req_i and its fields until a clock edge
// where cpu_stall_o=0; that edge retires the instruction. The memory side
// holds mem_enable_o and its fields stable until the edge where mem_ack_i=1
// (or the timeout expires); mem_ack_i is only looked at while mem_enable_o=1.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              timeout_o,
   output logic [31:0]       stall_cnt_o
);

   localparam int TCNT_W = $clog2(TIMEOUT);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              req_we_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [DATA_W-1:0] req_wdata_q;
   logic [TCNT_W-1:0] tcnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic              timeout_q;
   logic [31:0]       stall_cnt_q;

   logic latch_req, load_done, load_abort, set_timeout, access, stall, tmo_hit;

`ifdef DMEM_CTRL_WBUF_EN
   logic              wb_push, wb_pop, wb_full;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   dmem_wbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wbuf (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .push      (wb_push),
      .push_addr (cpu_addr_i),
      .push_data (cpu_wdata_i),
      .pop       (wb_pop),
      .full      (wb_full),
      .addr      (wb_addr),
      .data      (wb_data)
   );
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      latch_req   = 1'b0;
      load_done   = 1'b0;
      load_abort  = 1'b0;
      set_timeout = 1'b0;
      access      = 1'b0;
      stall       = 1'b0;
      tmo_hit     = (tcnt_q == TCNT_LAST);
`ifdef DMEM_CTRL_WBUF_EN
      wb_push     = 1'b0;
      wb_pop      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
`ifdef DMEM_CTRL_WBUF_EN
               // A store into an empty buffer retires now and drains later.
               if (cpu_we_i && !wb_full) begin
                  wb_push = 1'b1;
                  state_d = DRAIN;
               end else
`endif
               begin
                  stall     = 1'b1;
                  latch_req = 1'b1;
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            access = 1'b1;
            stall  = 1'b1;
            if (mem_ack_i) begin
               load_done = !req_we_q;
               state_d   = DONE;
            end else if (tmo_hit) begin
               set_timeout = 1'b1;
               load_abort  = !req_we_q;
               state_d     = DONE;
            end
         end
         // The pipeline advances on this cycle; cpu_req_i still shows the
         // finished instruction and must not start a second access.
         DONE: state_d = IDLE;
`ifdef DMEM_CTRL_WBUF_EN
         DRAIN: begin
            access = 1'b1;
            stall  = cpu_req_i;
            if (mem_ack_i) begin
               wb_pop  = 1'b1;
               state_d = IDLE;
            end else if (tmo_hit) begin
               wb_pop      = 1'b1;
               set_timeout = 1'b1;
               state_d     = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         tcnt_q      <= '0;
         rdata_q     <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (latch_req) begin
            req_we_q    <= cpu_we_i;
            req_addr_q  <= cpu_addr_i;
            req_wdata_q <= cpu_wdata_i;
         end
         // Counts cycles spent in the current memory access; cleared on exit
         // so every access starts its timeout window from zero.
         if (access && (state_d == state_q)) tcnt_q <= tcnt_q + TCNT_W'(1);
         else                                tcnt_q <= '0;
         if (load_done)       rdata_q <= mem_rdata_i;
         else if (load_abort) rdata_q <= '0;
         if (set_timeout) timeout_q <= 1'b1;
         if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   assign cpu_stall_o  = stall;
   assign cpu_rdata_o  = rdata_q;
   assign timeout_o    = timeout_q;
   assign stall_cnt_o  = stall_cnt_q;
   assign mem_enable_o = access;

`ifdef DMEM_CTRL_WBUF_EN
   assign mem_write_o = ((state_q == WAIT) && req_we_q) || (state_q == DRAIN);
   assign mem_addr_o  = (state_q == DRAIN) ? wb_addr : req_addr_q;
   assign mem_wdata_o = (state_q == DRAIN) ? wb_data : req_wdata_q;
`else
   assign mem_write_o = (state_q == WAIT) && req_we_q;
   assign mem_addr_o  = req_addr_q;
   assign mem_wdata_o = req_wdata_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized bench for dmem_ctrl with a queue-based scoreboard.
// The driver acts as the MEM stage, the responder acts as a variable-latency
// memory and checks each request/completion against the expected queues.
`timescale 1ns/1ps
module tb_dmem_ctrl;

   localparam int TMO    = 8;
   localparam int NWORDS = 16;
`ifdef DMEM_CTRL_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_req_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
   logic        cpu_stall_o, mem_enable_o, mem_write_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        timeout_o;
   logic [31:0] stall_cnt_o;

   dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_rdata_o  (cpu_rdata_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_ack_i    (mem_ack_i),
      .mem_rdata_i  (mem_rdata_i),
      .timeout_o    (timeout_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [64:0] exp_mem_q[$];   // {we, addr, wdata} per memory request
   logic [31:0] exp_rd_q[$];    // rdata expected when a load completes
   int          lat_q[$];       // ack latency per request, 0 = never ack
   logic [31:0] ref_mem[NWORDS];
   logic [31:0] sim_mem[NWORDS];
   int          exp_stall_total;
   logic [31:0] exp_rdata;
   logic        exp_to;
   int          drain_rem;
   int          mem_req_cnt = 0;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // ---------------- memory responder / monitor ----------------
   logic        busy = 1'b0;
   int          wcnt, cur_lat;
   logic        cur_we;
   logic [64:0] cur_req;
   logic [3:0]  cur_idx;

   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            busy      = 1'b0;
            mem_ack_i = 1'b0;
         end else if (mem_enable_o) begin
            if (!busy) begin
               busy    = 1'b1;
               wcnt    = 0;
               cur_req = {mem_write_o, mem_addr_o, mem_wdata_o};
               cur_we  = mem_write_o;
               cur_idx = mem_addr_o[5:2];
               mem_req_cnt++;
               cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
               if (exp_mem_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL mem_req_unexpected: got=%0h expected=none", cur_req);
               end else begin
                  check("mem_req", cur_req, exp_mem_q.pop_front());
               end
            end else begin
               check("mem_req_stable", {mem_write_o, mem_addr_o, mem_wdata_o}, cur_req);
            end
            wcnt++;
            if (cur_lat != 0 && wcnt == cur_lat) begin
               mem_ack_i = 1'b1;
               if (cur_we) sim_mem[cur_idx] = cur_req[31:0];
               else        mem_rdata_i = sim_mem[cur_idx];
            end else begin
               mem_ack_i   = 1'b0;
               mem_rdata_i = $urandom;
            end
         end else begin
            if (busy) begin
               busy = 1'b0;
               if (!cur_we) begin
                  if (exp_rd_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL load_done_unexpected: got=%0h expected=none", cpu_rdata_o);
                  end else begin
                     check("load_data", cpu_rdata_o, exp_rd_q.pop_front());
                  end
               end
            end
            // Stray acks while no access is open must be ignored by the DUT.
            mem_ack_i   = ($urandom_range(0, 3) == 0);
            mem_rdata_i = $urandom;
         end
      end
   end

   // ---------------- driver (MEM stage) with reference model ----------------
   task automatic issue(input logic req, input logic we, input int idx,
                        input logic [31:0] wdata, input int lat);
      int st_exp, st_got, wcyc;
      logic s;
      logic [31:0] addr;
      addr   = 32'(idx) << 2;
      wcyc   = (lat == 0) ? TMO : lat;
      st_exp = 0;
      if (req) begin
         exp_mem_q.push_back({we, addr, wdata});
         lat_q.push_back(lat);
         if (we) begin
            if (lat != 0) ref_mem[idx] = wdata;
         end else begin
            exp_rdata = (lat == 0) ? 32'd0 : ref_mem[idx];
            exp_rd_q.push_back(exp_rdata);
         end
         if (lat == 0) exp_to = 1'b1;
         if (WBUF) begin
            // Any request waits out a pending drain; a store then buffers.
            st_exp    = drain_rem;
            drain_rem = 0;
            if (we) drain_rem = wcyc;
            else    st_exp    = st_exp + 1 + wcyc;
         end else begin
            st_exp = 1 + wcyc;
         end
         cpu_req_i   = 1'b1;
         cpu_we_i    = we;
         cpu_addr_i  = addr;
         cpu_wdata_i = wdata;
      end else begin
         if (drain_rem > 0) drain_rem--;
         cpu_req_i   = 1'b0;
         cpu_we_i    = $urandom_range(0, 1);
         cpu_addr_i  = $urandom;
         cpu_wdata_i = $urandom;
      end
      exp_stall_total += st_exp;
      st_got = 0;
      forever begin
         #1;
         s = cpu_stall_o;
         @(negedge clk_i);
         if (!s) break;
         st_got++;
         if (st_got > 4 * TMO + 8) begin
            total++;
            bad++;
            $display("FAIL stall_budget: got=%0d expected=%0d", st_got, st_exp);
            break;
         end
      end
      check("stall_cycles", st_got, st_exp);
      check("stall_cnt", stall_cnt_o, exp_stall_total);
      check("rdata_hold", cpu_rdata_o, exp_rdata);
      if (drain_rem == 0) check("timeout_flag", timeout_o, exp_to);
   endtask

   task automatic random_instr();
      int kind, lat;
      kind = $urandom_range(0, 9);
      lat  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6);
      if (kind < 2)      issue(1'b0, 1'b0, 0, 32'd0, 1);
      else if (kind < 6) issue(1'b1, 1'b0, $urandom_range(0, NWORDS-1), $urandom, lat);
      else               issue(1'b1, 1'b1, $urandom_range(0, NWORDS-1), $urandom, lat);
   endtask

   task automatic model_reset();
      exp_stall_total = 0;
      exp_rdata       = '0;
      exp_to          = 1'b0;
      drain_rem       = 0;
   endtask

   task automatic reset_mid_wait();
      exp_mem_q.push_back({1'b0, 32'h4, 32'h0});
      lat_q.push_back(0);
      cpu_req_i   = 1'b1;
      cpu_we_i    = 1'b0;
      cpu_addr_i  = 32'h4;
      cpu_wdata_i = 32'h0;
      repeat (3) @(negedge clk_i);
      check("mid_wait_enable", mem_enable_o, 1'b1);
      #2;
      rst_i     = 1'b0;
      cpu_req_i = 1'b0;
      #1;
      check("rst_enable_drop", mem_enable_o, 1'b0);
      check("rst_stall", cpu_stall_o, 1'b0);
      check("rst_timeout_clr", timeout_o, 1'b0);
      check("rst_stall_cnt", stall_cnt_o, 32'd0);
      check("rst_rdata", cpu_rdata_o, 32'd0);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      @(negedge clk_i);
      model_reset();
      check("post_rst_enable", mem_enable_o, 1'b0);
      check("post_rst_stall_cnt", stall_cnt_o, 32'd0);
   endtask

   // ---------------- reset + main sequence ----------------
   initial begin
      int cnt0;
      logic [31:0] v;
      rst_i       = 1'b0;
      cpu_req_i   = 1'b0;
      cpu_we_i    = 1'b0;
      cpu_addr_i  = '0;
      cpu_wdata_i = '0;
      model_reset();
      for (int i = 0; i < NWORDS; i++) begin
         v          = $urandom;
         ref_mem[i] = v;
         sim_mem[i] = v;
      end
      ref_mem[0] = 32'd5;
      sim_mem[0] = 32'd5;

      repeat (3) @(negedge clk_i);
      check("reset_stall", cpu_stall_o, 1'b0);
      check("reset_enable", mem_enable_o, 1'b0);
      check("reset_write", mem_write_o, 1'b0);
      check("reset_addr", mem_addr_o, 32'd0);
      check("reset_wdata", mem_wdata_o, 32'd0);
      check("reset_rdata", cpu_rdata_o, 32'd0);
      check("reset_timeout", timeout_o, 1'b0);
      check("reset_stall_cnt", stall_cnt_o, 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);

      // Load word 5 from 0x00 with ack in the third WAIT cycle.
      issue(1'b1, 1'b0, 0, 32'd0, 3);
      // Store 0x1234 to 0x08, ack in the first WAIT cycle.
      issue(1'b1, 1'b1, 2, 32'h1234, 1);
      // Store then load with the request held through DONE.
      #1;
      cnt0 = mem_req_cnt;
      issue(1'b1, 1'b1, 3, 32'hA5A5_0001, 2);
      issue(1'b1, 1'b0, 3, 32'd0, 2);
      check("b2b_requests", mem_req_cnt - cnt0, 2);
      // Load that never gets an ack, then a normal load.
      issue(1'b1, 1'b0, 5, 32'd0, 0);
      issue(1'b1, 1'b0, 0, 32'd0, 2);
      // Store immediately followed by a load of the same word.
      issue(1'b1, 1'b1, 6, 32'hCAFE_0006, 3);
      issue(1'b1, 1'b0, 6, 32'd0, 2);

      for (int i = 0; i < 60; i++) random_instr();

      // A load flushes any pending drain before the reset test.
      issue(1'b1, 1'b0, 1, 32'd0, 1);
      reset_mid_wait();

      for (int i = 0; i < 20; i++) random_instr();
      for (int i = 0; i < 12; i++) issue(1'b0, 1'b0, 0, 32'd0, 1);

      check("mem_q_empty", exp_mem_q.size(), 0);
      check("rd_q_empty", exp_rd_q.size(), 0);
      check("lat_q_empty", lat_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #500_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Multi-cycle data-memory controller between the pipeline MEM stage and a variable-latency data memory. It accepts one load or store per MEM-stage instruction and drives a request/acknowledge handshake to the memory. While the access is outstanding it asserts a stall that freezes the pipeline, and it returns load data in a registered output. It also counts stall cycles for the bench's stall statistics.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- TIMEOUT, 64, maximum WAIT cycles before an access is aborted (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  MEM stage holds a load/store (MemRead|MemWrite)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  word-aligned byte address
- cpu_wdata_i  in  DATA_W  store data
- cpu_rdata_o  out  DATA_W  load data, registered
- cpu_stall_o  out  1  freeze PC/IF/ID/EX/MEM registers
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  memory request is a write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  one-cycle completion pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- timeout_o  out  1  sticky: an access was aborted
- stall_cnt_o  out  32  cycles with cpu_stall_o=1, saturating

## Operation
- States: IDLE, WAIT, DONE (plus DRAIN with write buffer).
- IDLE:
  - cpu_req_i=1 latches we, addr and wdata into the request registers; next state WAIT.
  - cpu_req_i=0 stays in IDLE.
- WAIT:
  - mem_enable_o=1; mem_write_o, mem_addr_o and mem_wdata_o come from the request registers and stay stable.
  - mem_ack_i=1: load captures mem_rdata_i into cpu_rdata_o; next state DONE.
  - Timeout counter reaches TIMEOUT-1 without ack: set timeout_o, load cpu_rdata_o=0, next state DONE.
- DONE:
  - cpu_stall_o=0 so the pipeline advances exactly once.
  - cpu_req_i is ignored in this state; it still shows the completed instruction.
  - Next state IDLE.
- cpu_stall_o = (IDLE & cpu_req_i & must_block) | WAIT | DRAIN-with-new-request. This is combinational from state and cpu_req_i.
- mem_ack_i outside WAIT or DRAIN is ignored.
- stall_cnt_o increments on every clock edge where cpu_stall_o=1, and saturates at 0xFFFF_FFFF.
- cpu_rdata_o keeps its value until the next load completes. Stores do not change it.

## Timing
- Reset (async assert): state=IDLE; all outputs 0; mem_enable_o drops immediately even mid-access. Deassertion takes effect at the next clk_i edge.
- Request in cycle 0 (IDLE): stall=1. Cycle 1: WAIT, mem_enable_o=1.
- Ack in cycle k (k≥1): DONE in cycle k+1, with rdata valid and stall=0.
- Minimum access is 2 stall cycles plus 1 DONE cycle.
- Back-to-back MEM instructions: the new request is seen in the IDLE cycle after DONE.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then DONE.
- Reset mid-WAIT discards the access. There is no retry, and timeout_o clears.

## Configuration
- DMEM_CTRL_WBUF_EN defined: a one-entry write buffer is compiled in.
  - A store in IDLE with the buffer empty goes to the buffer with no stall, and the state goes to DRAIN, which drives memory as WAIT does.
  - Any cpu_req_i during DRAIN stalls until the drain ack. The next state is then IDLE, which serves the new request normally.
  - A DRAIN timeout sets timeout_o.
- Undefined: stores take the same IDLE→WAIT→DONE path as loads, and DRAIN does not exist.

## Structure
- Package dmem_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, DONE, DRAIN)
  - the default ADDR_W, DATA_W and TIMEOUT constants
  - the stall counter saturation value
- Sub-module dmem_wbuf (only under DMEM_CTRL_WBUF_EN) holds the one-entry write buffer:
  - valid, addr and data registers
  - push/pop and full outputs

## Test plan
- Load from addr 0x00 with memory word 5, ack 3 cycles after mem_enable_o rises → cpu_rdata_o=5 in DONE; stall high 4 cycles; stall_cnt_o=4.
- Store 0x1234 to 0x08, ack in first WAIT cycle → mem_write_o=1, mem_addr_o=0x08, mem_wdata_o=0x1234; stall 2 cycles; cpu_rdata_o unchanged.
- Store then load with cpu_req_i held through DONE → exactly two memory requests, one DONE cycle each, with no duplicate issue.
- TIMEOUT=8, no ack → WAIT lasts 8 cycles, then timeout_o=1 (sticky), cpu_rdata_o=0, DONE; next load with ack still completes.
- rst_i low during WAIT → mem_enable_o=0 immediately; after release, IDLE and stall_cnt_o=0.
- With DMEM_CTRL_WBUF_EN: store then load next cycle → store has zero stall; load stalls until the drain ack, then does its own access.
